// File: rtl/window_event_counter_pkg.sv
// rtl/window_event_counter_pkg.sv - shared types and default widths for the window event counter
package window_event_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CNT_W_DEF  = 4;
    localparam int WIN_W_DEF  = 8;
    localparam int DROP_W_DEF = 4;

endpackage

// File: rtl/window_event_counter_sat_counter.sv
// rtl/window_event_counter_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter
    import window_event_counter_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         sat
);

    // sat flags that the counter sits at its ceiling, so a further inc is lost
    assign sat = &value;

    // clear wins over increment; increments at the ceiling are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !sat) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/window_event_counter.sv
// rtl/window_event_counter.sv - counts event pulses per programmable window, one-entry result holding register
module window_event_counter
    import window_event_counter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WIN_W  = WIN_W_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIN_W-1:0]  win_len,
    input  logic              evt_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              busy
);

    state_t             state;
    logic [WIN_W-1:0]   len;
    logic [WIN_W-1:0]   cyc;
    logic               win_sat;

    logic [CNT_W-1:0]   evt_val;
    logic               evt_full;
    logic               drop_full;

    logic               in_run;
    logic               last;
    logic               restart;
    logic               evt_clr;
    logic               evt_inc;
    logic               can_load;
    logic               drop_inc;
    logic [CNT_W-1:0]   commit_count;
    logic               commit_sat;

    assign in_run   = (state == RUN);
    assign last     = in_run && (cyc == (len - WIN_W'(1)));
    assign restart  = en && (win_len != '0);
    // a new window begins either from IDLE or back-to-back at a window end
    assign evt_clr  = (!in_run && restart) || last;
    assign evt_inc  = in_run && evt_in;
    assign can_load = !out_valid || out_ready;
    assign drop_inc = last && !can_load && !drop_full;

    // the last-cycle event is folded into the committed result directly
    assign commit_count = evt_val + CNT_W'(evt_in && !evt_full);
    assign commit_sat   = win_sat || (evt_in && evt_full);

    sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (evt_inc),
        .clr   (evt_clr),
        .value (evt_val),
        .sat   (evt_full)
    );

    sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .clr   (1'b0),
        .value (drop_cnt),
        .sat   (drop_full)
    );

    // window sequencing: latch length, advance cycle counter, restart or idle at window end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            len     <= '0;
            cyc     <= '0;
            win_sat <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (restart) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        len     <= win_len;
                        cyc     <= '0;
                        win_sat <= 1'b0;
                    end
                end
                RUN: begin
                    if (last) begin
                        if (restart) begin
                            len     <= win_len;
                            cyc     <= '0;
                            win_sat <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                        if (evt_in && evt_full) begin
                            win_sat <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // holding register: load on commit when free or being drained, otherwise drain on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (last && can_load) begin
            out_valid <= 1'b1;
            out_count <= commit_count;
            out_sat   <= commit_sat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_event_counter.sv
// tb/tb_window_event_counter.sv - scoreboard bench for window_event_counter
module tb_window_event_counter;

    localparam int CNT_W  = 4;
    localparam int WIN_W  = 8;
    localparam int DROP_W = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk;
    logic              rst;
    logic              en;
    logic [WIN_W-1:0]  win_len;
    logic              evt_in;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;
    logic [DROP_W-1:0] drop_cnt;
    logic              busy;

    window_event_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .DROP_W(DROP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .win_len   (win_len),
        .evt_in    (evt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_sat   (out_sat),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit sat;
    } result_t;

    result_t exp_q[$];

    int vectors    = 0;
    int miscompares = 0;
    bit done = 0;

    // reference model: window bookkeeping with plain integers
    bit m_run;
    int m_len;
    int m_pos;
    int m_events;
    bit m_valid;
    int m_drop;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_len = 0; m_pos = 0; m_events = 0;
        m_valid = 0; m_drop = 0;
        exp_q.delete();
    endtask

    // what happens at a rising edge, given the inputs held during the cycle before it
    task automatic model_edge();
        bit accepted;
        bit committed;
        result_t r;
        if (rst) begin
            model_reset();
            return;
        end
        accepted  = m_valid && out_ready;
        committed = 0;
        if (!m_run) begin
            if (en && win_len != 0) begin
                m_run = 1; m_len = int'(win_len); m_pos = 0; m_events = 0;
            end
        end else begin
            m_events += int'(evt_in);
            if (m_pos == m_len - 1) begin
                committed = 1;
                r.count = (m_events > CNT_MAX) ? CNT_MAX : m_events;
                r.sat   = (m_events > CNT_MAX);
                if (!m_valid || out_ready) begin
                    exp_q.push_back(r);
                    m_valid = 1;
                end else begin
                    m_drop = (m_drop >= DROP_MAX) ? DROP_MAX : m_drop + 1;
                end
                if (en && win_len != 0) begin
                    m_len = int'(win_len); m_pos = 0; m_events = 0;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_pos++;
            end
        end
        if (accepted && !committed) m_valid = 0;
    endtask

    task automatic step(input bit e, input int wl, input bit ev, input bit rdy);
        en = e; win_len = WIN_W'(wl); evt_in = ev; out_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // asynchronous reset landing mid-cycle; outputs must clear before the next edge
    task automatic mid_cycle_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_busy",  int'(busy), 0);
        check("async_rst_count", int'(out_count), 0);
        check("async_rst_drop",  int'(drop_cnt), 0);
        step(1, 5, 1, 0);
        step(1, 5, 0, 0);
        rst = 1'b0;
    endtask

    // monitor: per-cycle control outputs against the model, results popped on each handshake
    initial begin
        result_t r;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            check("out_valid", int'(out_valid), int'(m_valid));
            check("busy",      int'(busy),      int'(m_run));
            check("drop_cnt",  int'(drop_cnt),  m_drop);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("out_count", int'(out_count), r.count);
                    check("out_sat",   int'(out_sat),   int'(r.sat));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; win_len = '0; evt_in = 1'b0; out_ready = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // reset held with events toggling
        for (int i = 0; i < 4; i++) step(1, 3, i % 2, 1);
        rst = 1'b0;

        // basic window: events on RUN cycles 0, 2, 4
        step(1, 5, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 5, (i % 2) == 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // zero-length window is a no-op
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1);

        // saturation
        step(1, 20, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 20, 1, 1);
        step(0, 0, 0, 1);

        // exactly 15 events fills without saturating
        step(1, 15, 0, 1);
        for (int i = 0; i < 15; i++) step(0, 15, 1, 1);
        step(0, 0, 0, 1);

        // backpressure: four windows of length 2, consumer stalled
        step(1, 2, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 2, i[0] ^ i[1], 0);
        check("bp_drop_cnt", int'(drop_cnt), 3);
        for (int i = 0; i < 6; i++) step(i < 3, 2, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // accept coinciding with commit: length 1 windows with ready high
        step(1, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 1, i[0], 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // reset in the middle of a 10-cycle window, then a fresh window
        step(1, 10, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 10, 1, 1);
        mid_cycle_reset();
        step(1, 10, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 10, i < 7, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int wl;
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0)      wl = 0;
            else if (sel < 3)  wl = $urandom_range(16, 24);
            else               wl = $urandom_range(1, 6);
            step($urandom_range(0, 9) < 7, wl, $urandom_range(0, 1), $urandom_range(0, 9) < 6);
        end

        // drain
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1);
        check("queue_drained", exp_q.size(), 0);

        done = 1;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
